// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter
//   Multi-channel duty-cycle / edge-rate meter. Each channel's asynchronous
//   input is synchronised, then either its high-time cycles (mode 0) or its
//   rising edges (mode 1) are counted over a common programmable window of
//   window_len+1 enabled cycles. All channel results and stuck flags are
//   latched together at the window boundary and announced with valid.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   low pauses the window and accumulators
//   mode       in   0 = high-time count, 1 = rising-edge count (sampled at window start)
//   window_len in   window length minus one (sampled at window start)
//   ring_in    in   asynchronous measured inputs, one per channel
//   value      out  latched results, channel i at [i*WIDTH +: WIDTH]
//   valid      out  one-cycle strobe when value/flags update
//   stuck_high out  per-channel stuck-high flag
//   stuck_low  out  per-channel stuck-low flag
module duty_cycle_meter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          window_len,
  input  logic [CHANNELS-1:0]       ring_in,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic                      valid,
  output logic [CHANNELS-1:0]       stuck_high,
  output logic [CHANNELS-1:0]       stuck_low
);

  logic [CHANNELS-1:0]       sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]       s;
  logic [CHANNELS-1:0]       s_d_q;
  logic [CHANNELS-1:0]       inc;

  logic [WIDTH-1:0]          win_cnt_q, win_cnt_d;
  logic [WIDTH-1:0]          len_q, len_d;
  logic                      mode_q, mode_d;
  logic [WIDTH-1:0]          acc_q [CHANNELS];
  logic [WIDTH-1:0]          acc_d [CHANNELS];
  logic [WIDTH-1:0]          total [CHANNELS];

  logic [CHANNELS*WIDTH-1:0] value_q, value_d;
  logic                      valid_q, valid_d;
  logic [CHANNELS-1:0]       sh_q, sh_d;
  logic [CHANNELS-1:0]       sl_q, sl_d;

  logic                      last;
  logic [WIDTH:0]            full_len;

  // Add a single increment, holding at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] a,
                                               input logic b);
    if (b && (a == '1)) return a;
    return a + WIDTH'(b);
  endfunction

  always_comb begin
    s        = sync_q[SYNC_STAGES-1];
    inc      = mode_q ? (s & ~s_d_q) : s;
    last     = (win_cnt_q == len_q);
    full_len = {1'b0, len_q} + {{WIDTH{1'b0}}, 1'b1};
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      total[i] = sat_inc(acc_q[i], inc[i]);
    end
  end

  always_comb begin
    win_cnt_d = win_cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    sh_d      = sh_q;
    sl_d      = sl_q;
    if (enable) begin
      if (!last) begin
        win_cnt_d = win_cnt_q + 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          acc_d[i] = total[i];
        end
      end else begin
        // Last window cycle: this cycle's increment is folded into the
        // reported total so the next window starts without a gap.
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          value_d[i*WIDTH +: WIDTH] = total[i];
          acc_d[i] = '0;
          if (mode_q) begin
            sh_d[i] = (total[i] == '0) &&  s[i];
            sl_d[i] = (total[i] == '0) && !s[i];
          end else begin
            // A full 2^WIDTH-cycle window of high saturates one short of len+1.
            sh_d[i] = ({1'b0, total[i]} == full_len) ||
                      ((len_q == '1) && (total[i] == '1));
            sl_d[i] = (total[i] == '0);
          end
        end
        win_cnt_d = '0;
        len_d     = window_len;
        mode_d    = mode;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      s_d_q     <= '0;
      win_cnt_q <= '0;
      len_q     <= window_len;
      mode_q    <= mode;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      value_q   <= '0;
      valid_q   <= 1'b0;
      sh_q      <= '0;
      sl_q      <= '0;
    end else begin
      sync_q[0] <= ring_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      s_d_q     <= s;
      win_cnt_q <= win_cnt_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      sh_q      <= sh_d;
      sl_q      <= sl_d;
    end
  end

  assign value      = value_q;
  assign valid      = valid_q;
  assign stuck_high = sh_q;
  assign stuck_low  = sl_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Bench for duty_cycle_meter (4 channels, 8-bit, 2 sync stages): directed
// scenarios followed by randomized traffic, every cycle compared against a
// window-level reference model.
module tb_duty_cycle_meter;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SS = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              mode;
  logic [W-1:0]      window_len;
  logic [CH-1:0]     ring_in;
  logic [CH*W-1:0]   value;
  logic              valid;
  logic [CH-1:0]     stuck_high;
  logic [CH-1:0]     stuck_low;

  duty_cycle_meter #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .window_len(window_len),
    .ring_in   (ring_in),
    .value     (value),
    .valid     (valid),
    .stuck_high(stuck_high),
    .stuck_low (stuck_low)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: input samples delayed by the synchroniser depth, and a
  // window that closes after len+1 enabled cycles.
  logic [CH-1:0]   d [0:SS];
  int              m_len, m_cnt;
  logic            m_mode;
  int              m_tot [CH];
  logic [CH*W-1:0] e_value;
  logic            e_valid;
  logic [CH-1:0]   e_sh, e_sl;

  // Observation bookkeeping and waveform generator.
  int              cyc = 0;
  int              last_v = 0, prev_v = 0;
  logic [CH*W-1:0] cap_val;
  logic [CH-1:0]   cap_sh, cap_sl;
  int              gen_kind = 0;
  int              gen_ph = 0;
  int              rst_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] s, sd, inc;
    int sat;
    if (reset) begin
      for (int j = 0; j <= SS; j++) d[j] = '0;
      m_len  = int'(window_len);
      m_mode = mode;
      m_cnt  = 0;
      for (int i = 0; i < CH; i++) m_tot[i] = 0;
      e_value = '0;
      e_valid = 1'b0;
      e_sh    = '0;
      e_sl    = '0;
    end else begin
      s  = d[SS-1];
      sd = d[SS];
      for (int j = SS; j > 0; j--) d[j] = d[j-1];
      d[0] = ring_in;
      e_valid = 1'b0;
      if (enable) begin
        inc = m_mode ? (s & ~sd) : s;
        m_cnt++;
        for (int i = 0; i < CH; i++) m_tot[i] += int'(inc[i]);
        if (m_cnt == m_len + 1) begin
          for (int i = 0; i < CH; i++) begin
            sat = (m_tot[i] > 255) ? 255 : m_tot[i];
            e_value[i*W +: W] = W'(sat);
            if (!m_mode) begin
              e_sh[i] = (sat == m_len + 1) || (m_len == 255 && sat == 255);
              e_sl[i] = (sat == 0);
            end else begin
              e_sh[i] = (sat == 0) &&  s[i];
              e_sl[i] = (sat == 0) && !s[i];
            end
            m_tot[i] = 0;
          end
          e_valid = 1'b1;
          m_cnt   = 0;
          m_len   = int'(window_len);
          m_mode  = mode;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("valid", 32'(valid), 32'(e_valid));
    chk("value", 32'(value), 32'(e_value));
    chk("stuck_high", 32'(stuck_high), 32'(e_sh));
    chk("stuck_low", 32'(stuck_low), 32'(e_sl));
    if (valid) begin
      prev_v  = last_v;
      last_v  = cyc;
      cap_val = value;
      cap_sh  = stuck_high;
      cap_sl  = stuck_low;
    end
    gen_ph++;
    case (gen_kind)
      1: ring_in[0] = ((gen_ph % 100) < 30);
      2: ring_in[0] = ((gen_ph % 10) < 5);
      3: ring_in[0] = ((gen_ph % 20) < 10);
      default: ;
    endcase
  endtask

  task automatic wait_valid(input int maxc);
    bit seen = 1'b0;
    for (int n = 0; n < maxc && !seen; n++) begin
      tick();
      if (valid) seen = 1'b1;
    end
    chk("valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    mode       = 1'b0;
    window_len = 8'd99;
    ring_in    = '0;
    tick();
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    reset = 1'b0;

    // 30/70 square wave on ch0, 100-cycle windows.
    gen_kind = 1;
    gen_ph   = 0;
    wait_valid(150);
    wait_valid(150);
    wait_valid(150);
    chk("duty30_value", 32'(cap_val[0 +: W]), 32'd30);
    chk("duty30_period", 32'(last_v - prev_v), 32'd100);
    chk("duty30_sh", 32'(cap_sh), 32'h0);
    chk("duty30_sl", 32'(cap_sl), 32'he);

    // Saturation and stuck flags over a 256-cycle window.
    gen_kind   = 0;
    ring_in    = 4'b0010;
    window_len = 8'd255;
    wait_valid(150);
    wait_valid(300);
    chk("sat_ch1_value", 32'(cap_val[W +: W]), 32'd255);
    chk("sat_ch1_sh", 32'(cap_sh[1]), 32'd1);
    chk("sat_ch2_value", 32'(cap_val[2*W +: W]), 32'd0);
    chk("sat_ch2_sl", 32'(cap_sl[2]), 32'd1);
    chk("sat_period", 32'(last_v - prev_v), 32'd256);

    // Edge counting: period-10 clock on ch0, ch1 held high.
    mode       = 1'b1;
    window_len = 8'd99;
    gen_kind   = 2;
    wait_valid(300);
    wait_valid(150);
    chk("edge_value", 32'(cap_val[0 +: W]), 32'd10);
    chk("edge_ch1_value", 32'(cap_val[W +: W]), 32'd0);
    chk("edge_ch1_sh", 32'(cap_sh), 32'h2);
    chk("edge_sl", 32'(cap_sl), 32'hc);
    chk("edge_period", 32'(last_v - prev_v), 32'd100);

    // 50% wave with enable dropped for 40 cycles mid-window.
    mode       = 1'b0;
    ring_in[1] = 1'b0;
    gen_kind   = 3;
    wait_valid(150);
    wait_valid(150);
    chk("half_value", 32'(cap_val[0 +: W]), 32'd50);
    run(30);
    enable = 1'b0;
    run(40);
    enable = 1'b1;
    wait_valid(150);
    chk("pause_period", 32'(last_v - prev_v), 32'd140);
    chk("pause_value", 32'(cap_val[0 +: W]), 32'd50);

    // Window length changed mid-window takes effect on the next window.
    run(30);
    window_len = 8'd49;
    wait_valid(150);
    chk("len_change_cur", 32'(last_v - prev_v), 32'd100);
    wait_valid(150);
    chk("len_change_next", 32'(last_v - prev_v), 32'd50);

    // Reset 60 cycles into a window.
    window_len = 8'd99;
    wait_valid(150);
    run(60);
    reset = 1'b1;
    tick();
    rst_cyc = cyc;
    chk("midrst_value", 32'(value), 32'd0);
    chk("midrst_flags", 32'({stuck_high, stuck_low}), 32'd0);
    reset = 1'b0;
    wait_valid(150);
    chk("midrst_first_window", 32'(last_v - rst_cyc), 32'd100);

    // One-cycle windows: valid every enabled cycle.
    window_len = 8'd0;
    wait_valid(150);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("len0_valid", 32'(valid), 32'd1);
    end

    // Randomized traffic.
    gen_kind = 0;
    for (int n = 0; n < 1500; n++) begin
      reset  = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) window_len = W'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) ring_in[c] = ~ring_in[c];
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
